// File: rtl/timing_engine_seq_pkg.sv
// Shared types and width helpers for the radio timing sequencer.
package pa_timing_engine;

  // state    | meaning
  // IDLE     | radio off, arbitrating synced enable requests
  // WAIT_PLL | radio on, waiting for PLL lock
  // RAMP_UP  | PLL locked, counting tArstFs before the front end is usable
  // ACTIVE   | owner holds the radio, RX enable follows its request
  // RAMP_DN  | radio held on for tRampDn cycles after disable / lock loss
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PLL = 3'd1,
    RAMP_UP  = 3'd2,
    ACTIVE   = 3'd3,
    RAMP_DN  = 3'd4
  } te_state_t;

  localparam int SIZE_T_ARSTFS_DEF = 8;
  localparam int SIZE_T_RAMPDN_DEF = 8;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/timing_engine_seq_sync_cell.sv
// Single-bit multi-flop synchroniser for an asynchronous request line.
module sync_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstN,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/timing_engine_seq.sv
// Radio timing sequencer: synchronises per-channel enable/RX requests, grants one owner
// and steps the radio through PLL settle, ramp-up, active and ramp-down.
module timing_engine_seq
  import pa_timing_engine::*;
#(
  parameter int NUM_CH        = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int SIZE_T_ARSTFS = SIZE_T_ARSTFS_DEF,
  parameter int SIZE_T_RAMPDN = SIZE_T_RAMPDN_DEF
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic [NUM_CH-1:0]           reqEnable,
  input  logic [NUM_CH-1:0]           reqRxEn,
  input  logic                        pllSettled,
  input  logic [SIZE_T_ARSTFS-1:0]    tArstFs,
  input  logic [SIZE_T_RAMPDN-1:0]    tRampDn,
  output logic                        radioEnable,
  output logic                        radioRxEn,
  output logic [ch_width(NUM_CH)-1:0] activeCh,
  output logic                        busy,
  output logic                        pllLostErr
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int CNT_W = max_int(SIZE_T_ARSTFS, SIZE_T_RAMPDN);

  logic [NUM_CH-1:0] en_sync;
  logic [NUM_CH-1:0] rx_sync;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_en (
      .clk  (clk),
      .rstN (rstN),
      .d    (reqEnable[g]),
      .q    (en_sync[g])
    );
    sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
      .clk  (clk),
      .rstN (rstN),
      .d    (reqRxEn[g]),
      .q    (rx_sync[g])
    );
  end

  te_state_t        state;
  te_state_t        next_state;
  te_state_t        dn_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] dn_val;
  logic             cnt_load;
  logic             grant_load;
  logic             lost_next;
  logic [CH_W-1:0]  grant_ch;
  logic             any_req;
  logic             own_en;
  logic             own_rx;

  // Lowest-index synced request wins; only consulted while IDLE.
  always_comb begin
    grant_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (en_sync[i]) begin
        grant_ch = CH_W'(i);
      end
    end
  end

  assign any_req  = |en_sync;
  assign own_en   = en_sync[activeCh];
  assign own_rx   = rx_sync[activeCh];
  assign dn_val   = CNT_W'(tRampDn);
  assign dn_state = (tRampDn == '0) ? IDLE : RAMP_DN;

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    grant_load = 1'b0;
    lost_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          next_state = WAIT_PLL;
          grant_load = 1'b1;
        end
      end
      WAIT_PLL: begin
        if (!own_en) begin
          next_state = IDLE;
        end else if (pllSettled) begin
          if (tArstFs == '0) begin
            next_state = ACTIVE;
          end else begin
            next_state = RAMP_UP;
            cnt_load   = 1'b1;
            cnt_val    = CNT_W'(tArstFs);
          end
        end
      end
      RAMP_UP: begin
        if (!own_en) begin
          next_state = dn_state;
          cnt_load   = 1'b1;
          cnt_val    = dn_val;
        end else if (!pllSettled) begin
          next_state = WAIT_PLL;
        end else if (cnt <= CNT_W'(1)) begin
          next_state = ACTIVE;
        end
      end
      ACTIVE: begin
        // Lock loss outranks a simultaneous disable so the error is never masked.
        if (!pllSettled || !own_en) begin
          lost_next  = !pllSettled;
          next_state = dn_state;
          cnt_load   = 1'b1;
          cnt_val    = dn_val;
        end
      end
      RAMP_DN: begin
        if (cnt <= CNT_W'(1)) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= IDLE;
      cnt         <= '0;
      activeCh    <= '0;
      radioEnable <= 1'b0;
      radioRxEn   <= 1'b0;
      busy        <= 1'b0;
      pllLostErr  <= 1'b0;
    end else begin
      state <= next_state;
      if (cnt_load) begin
        cnt <= cnt_val;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (grant_load) begin
        activeCh <= grant_ch;
      end
      radioEnable <= (next_state != IDLE);
      busy        <= (next_state != IDLE);
      radioRxEn   <= (next_state == ACTIVE) && own_rx;
      pllLostErr  <= lost_next;
    end
  end

endmodule

// File: tb/tb_timing_engine_seq.sv
// Directed and randomized bench for timing_engine_seq against a cycle-level reference model.
module tb_timing_engine_seq;

  localparam int NUM_CH      = 2;
  localparam int SYNC_STAGES = 2;
  localparam int PH_OFF = 0, PH_PLL = 1, PH_UP = 2, PH_ON = 3, PH_DN = 4;

  logic              clk        = 1'b0;
  logic              rstN       = 1'b0;
  logic [NUM_CH-1:0] reqEnable  = '0;
  logic [NUM_CH-1:0] reqRxEn    = '0;
  logic              pllSettled = 1'b0;
  logic [7:0]        tArstFs    = '0;
  logic [7:0]        tRampDn    = '0;
  logic              radioEnable, radioRxEn, busy, pllLostErr;
  logic [0:0]        activeCh;

  int checks = 0;
  int errors = 0;
  int n;

  int m_phase, m_left, m_owner;
  bit m_err, m_rx;
  logic [NUM_CH-1:0] en_pipe [SYNC_STAGES];
  logic [NUM_CH-1:0] rx_pipe [SYNC_STAGES];

  always #5 clk = ~clk;

  timing_engine_seq #(
    .NUM_CH        (NUM_CH),
    .SYNC_STAGES   (SYNC_STAGES),
    .SIZE_T_ARSTFS (8),
    .SIZE_T_RAMPDN (8)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .reqEnable   (reqEnable),
    .reqRxEn     (reqRxEn),
    .pllSettled  (pllSettled),
    .tArstFs     (tArstFs),
    .tRampDn     (tRampDn),
    .radioEnable (radioEnable),
    .radioRxEn   (radioRxEn),
    .activeCh    (activeCh),
    .busy        (busy),
    .pllLostErr  (pllLostErr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_OFF;
    m_left  = 0;
    m_owner = 0;
    m_err   = 1'b0;
    m_rx    = 1'b0;
    for (int i = 0; i < SYNC_STAGES; i++) begin
      en_pipe[i] = '0;
      rx_pipe[i] = '0;
    end
  endtask

  task automatic model_start_dn();
    if (tRampDn == 0) begin
      m_phase = PH_OFF;
    end else begin
      m_phase = PH_DN;
      m_left  = int'(tRampDn);
    end
  endtask

  // One clock edge of the reference: requests seen by the sequencer are those
  // driven SYNC_STAGES edges earlier; time windows count remaining cycles.
  task automatic model_edge();
    logic [NUM_CH-1:0] se, sr;
    bit own;
    se = en_pipe[SYNC_STAGES-1];
    sr = rx_pipe[SYNC_STAGES-1];
    for (int i = SYNC_STAGES - 1; i > 0; i--) begin
      en_pipe[i] = en_pipe[i-1];
      rx_pipe[i] = rx_pipe[i-1];
    end
    en_pipe[0] = reqEnable;
    rx_pipe[0] = reqRxEn;
    own   = se[m_owner];
    m_err = 1'b0;
    case (m_phase)
      PH_OFF: begin
        if (se != '0) begin
          for (int i = NUM_CH - 1; i >= 0; i--) if (se[i]) m_owner = i;
          m_phase = PH_PLL;
        end
      end
      PH_PLL: begin
        if (!own) m_phase = PH_OFF;
        else if (pllSettled) begin
          if (tArstFs == 0) m_phase = PH_ON;
          else begin
            m_phase = PH_UP;
            m_left  = int'(tArstFs);
          end
        end
      end
      PH_UP: begin
        if (!own) model_start_dn();
        else if (!pllSettled) m_phase = PH_PLL;
        else begin
          m_left--;
          if (m_left == 0) m_phase = PH_ON;
        end
      end
      PH_ON: begin
        if (!pllSettled || !own) begin
          m_err = !pllSettled;
          model_start_dn();
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_phase = PH_OFF;
      end
    endcase
    m_rx = (m_phase == PH_ON) && sr[m_owner];
  endtask

  task automatic check_all();
    check("radioEnable", 32'(radioEnable), 32'(m_phase != PH_OFF));
    check("busy",        32'(busy),        32'(m_phase != PH_OFF));
    check("radioRxEn",   32'(radioRxEn),   32'(m_rx));
    check("pllLostErr",  32'(pllLostErr),  32'(m_err));
    check("activeCh",    32'(activeCh),    32'(m_owner));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rstN) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_en(input logic v, input int budget, output int cnt);
    cnt = 0;
    do begin
      cycle();
      cnt++;
    end while (radioEnable !== v && cnt <= budget);
  endtask

  initial begin
    model_reset();
    repeat (3) cycle();
    rstN = 1'b1;
    repeat (100) cycle();

    // Single channel, settle 5 cycles after request, tArstFs = 10.
    tArstFs = 8'd10;
    tRampDn = 8'd4;
    reqEnable[0] = 1'b1;
    reqRxEn[0]   = 1'b1;
    wait_en(1'b1, 20, n);
    check("en_latency", 32'(n), 32'(SYNC_STAGES + 1));
    check("owner_ch0", 32'(activeCh), 32'd0);
    repeat (4) cycle();
    pllSettled = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (radioRxEn !== 1'b1 && n <= 40);
    check("settle_to_active", 32'(n), 32'(tArstFs) + 32'd1);

    // Lock loss while ACTIVE.
    repeat (5) cycle();
    pllSettled = 1'b0;
    cycle();
    check("pll_lost_pulse", 32'(pllLostErr), 32'd1);
    check("rx_off_on_loss", 32'(radioRxEn), 32'd0);
    cycle();
    check("pll_lost_single", 32'(pllLostErr), 32'd0);
    wait_en(1'b0, 20, n);
    check("rampdn_len", 32'(n + 2), 32'(tRampDn) + 32'd1);
    reqEnable = '0;
    reqRxEn   = '0;
    repeat (8) cycle();

    // Two simultaneous requests: lowest index owns, the other waits one IDLE cycle.
    tArstFs    = 8'd3;
    tRampDn    = 8'd4;
    pllSettled = 1'b1;
    reqEnable  = 2'b11;
    reqRxEn    = 2'b11;
    wait_en(1'b1, 20, n);
    check("owner_lowest", 32'(activeCh), 32'd0);
    repeat (8) cycle();
    check("ch0_active_rx", 32'(radioRxEn), 32'd1);
    reqEnable[0] = 1'b0;
    wait_en(1'b0, 20, n);
    check("drop_to_idle", 32'(n), 32'(SYNC_STAGES + 1) + 32'(tRampDn));
    cycle();
    check("regrant_en", 32'(radioEnable), 32'd1);
    check("regrant_ch1", 32'(activeCh), 32'd1);
    reqEnable = '0;
    reqRxEn   = '0;
    repeat (10) cycle();

    // Zero ramp-up and zero ramp-down.
    tArstFs    = 8'd0;
    tRampDn    = 8'd0;
    pllSettled = 1'b0;
    reqEnable[0] = 1'b1;
    reqRxEn[0]   = 1'b1;
    wait_en(1'b1, 20, n);
    repeat (2) cycle();
    pllSettled = 1'b1;
    cycle();
    check("zero_rampup", 32'(radioRxEn), 32'd1);
    reqEnable = '0;
    wait_en(1'b0, 20, n);
    check("zero_rampdn", 32'(n), 32'(SYNC_STAGES + 1));
    reqRxEn = '0;
    repeat (5) cycle();

    // Reset asserted during RAMP_UP, request still held afterwards.
    tArstFs      = 8'd50;
    reqEnable[0] = 1'b1;
    wait_en(1'b1, 20, n);
    repeat (5) cycle();
    check("in_rampup_busy", 32'(busy), 32'd1);
    #2 rstN = 1'b0;
    #1;
    check("rst_async_en", 32'(radioEnable), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    model_reset();
    cycle();
    rstN = 1'b1;
    wait_en(1'b1, 20, n);
    check("restart_latency", 32'(n), 32'(SYNC_STAGES + 1));
    check("restart_owner", 32'(activeCh), 32'd0);
    reqEnable = '0;
    tArstFs   = 8'd2;
    repeat (10) cycle();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      int idx;
      if (k % 50 == 0) begin
        tArstFs = 8'($urandom_range(6));
        tRampDn = 8'($urandom_range(6));
      end
      if ($urandom_range(7) == 0) begin
        idx = $urandom_range(NUM_CH - 1);
        reqEnable[idx] = ~reqEnable[idx];
      end
      if ($urandom_range(5) == 0) begin
        idx = $urandom_range(NUM_CH - 1);
        reqRxEn[idx] = ~reqRxEn[idx];
      end
      if ($urandom_range(11) == 0) pllSettled = ~pllSettled;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
